// File: rtl/riscv_pkg.sv
// Shared definitions for the front end: widths, reset PC, major opcodes
// and the fetch-stage state encoding.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
  localparam int ILEN = 32;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Small register-based FIFO with push/pop/flush, occupancy count and a
// combinational head view. Callers must never push into a full queue.
module fetch_queue #(
  parameter int DEPTH = 2,
  parameter int W     = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [W-1:0]               head
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  entry_w [DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          do_push, do_pop;

  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && (count_reg != '0);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [W-1:0] entry_reg;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          entry_reg <= '0;
        end else if (do_push && (wr_ptr_reg == PW'(gi))) begin
          entry_reg <= push_data;
        end
      end
      assign entry_w[gi] = entry_reg;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
    end
  end

  assign count = count_reg;
  assign head  = entry_w[rd_ptr_reg];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, credit-limited memory requests, in-order response
// buffering and branch redirect with stale-response draining.
// Optional FETCH_STATS_EN adds a 32-bit delivered-instruction counter.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [ILEN-1:0] out_instr,
  output logic [6:0]      out_opcode
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]     fetch_count
`endif
);

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_e         state_reg, state_next;
  logic [XLEN-1:0]      pc_reg;
  logic [CW-1:0]        drop_cnt_reg, drop_cnt_next;
  logic [CW-1:0]        q_count, a_count;
  logic [XLEN+ILEN-1:0] q_head;
  logic [XLEN-1:0]      a_head;
  logic [CW:0]          credit_used;
  logic                 redirect, req_fire, rsp_fire, rsp_keep, pop_fire;

  assign redirect    = branch_taken && (state_reg != BOOT);
  assign credit_used = {1'b0, a_count} + {1'b0, q_count};
  assign req_fire    = imem_req_valid && imem_req_ready;
  assign rsp_fire    = imem_rsp_valid && (state_reg != BOOT);
  assign rsp_keep    = rsp_fire && (state_reg == RUN) && !redirect;
  assign pop_fire    = out_valid && out_ready && !redirect;

  // Remaining stale responses; a redirect in DRAIN keeps counting the old ones down.
  always_comb begin
    drop_cnt_next = drop_cnt_reg;
    if (redirect) begin
      drop_cnt_next = ((state_reg == DRAIN) ? drop_cnt_reg : a_count) - CW'(imem_rsp_valid);
    end else if ((state_reg == DRAIN) && imem_rsp_valid) begin
      drop_cnt_next = drop_cnt_reg - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= BOOT;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      BOOT:    state_next = RUN;
      RUN:     if (redirect) state_next = (drop_cnt_next != '0) ? DRAIN : RUN;
      DRAIN:   state_next = (drop_cnt_next != '0) ? DRAIN : RUN;
      default: state_next = BOOT;
    endcase
  end

  always_comb begin
    imem_req_valid = (state_reg == RUN) && !branch_taken && (credit_used < (CW+1)'(DEPTH));
    imem_req_addr  = pc_reg;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg       <= RESET_PC;
      drop_cnt_reg <= '0;
    end else begin
      drop_cnt_reg <= drop_cnt_next;
      if (redirect) begin
        pc_reg <= {branch_target[XLEN-1:2], 2'b00};
      end else if (req_fire) begin
        pc_reg <= pc_reg + XLEN'(4);
      end
    end
  end

  // Addresses of in-flight requests, consumed by every response including stale ones.
  fetch_queue #(.DEPTH(DEPTH), .W(XLEN)) u_addr_q (
    .clk       (clk),
    .reset     (reset),
    .push      (req_fire),
    .push_data (pc_reg),
    .pop       (rsp_fire),
    .flush     (1'b0),
    .count     (a_count),
    .head      (a_head)
  );

  fetch_queue #(.DEPTH(DEPTH), .W(XLEN + ILEN)) u_out_q (
    .clk       (clk),
    .reset     (reset),
    .push      (rsp_keep),
    .push_data ({a_head, imem_rsp_data}),
    .pop       (pop_fire),
    .flush     (redirect),
    .count     (q_count),
    .head      (q_head)
  );

  assign out_valid  = (q_count != '0);
  assign out_pc     = q_head[XLEN+ILEN-1:ILEN];
  assign out_instr  = q_head[ILEN-1:0];
  assign out_opcode = q_head[6:0];

`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_count_reg <= '0;
    end else if (pop_fire) begin
      fetch_count_reg <= fetch_count_reg + 32'd1;
    end
  end

  assign fetch_count = fetch_count_reg;
`endif

endmodule
